// File: rtl/writeback_regfile_pkg.sv
// Shared CPU definitions: opcode encodings, datapath defaults and the
// register-writing opcode predicate used by writeback, decode and hazard logic.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int RET_W  = 16;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  function automatic logic writes_reg(input logic [2:0] opcode);
    return !(opcode == OP_SW || opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// Memory-stage slot, decode read ports and writeback/status outputs of the
// writeback stage, grouped so producers and consumers bind one bundle.
interface writeback_regfile_if
  import cpu_pkg::*;
#(
  parameter int DW  = DATA_W,
  parameter int AW  = REG_AW,
  parameter int RW  = RET_W
);
  // No handshake: the slot is consumed every cycle; bubble_in marks an empty
  // slot and wb_valid announces a commit at the next rising edge.
  logic          bubble_in;
  logic [2:0]    opcode_in;
  logic [AW-1:0] tgt_in;
  logic [DW-1:0] result_in;
  logic [DW-1:0] mem_rdata;
  logic          halt_in;
  logic [AW-1:0] ra_addr;
  logic [AW-1:0] rb_addr;
  logic [DW-1:0] ra_data;
  logic [DW-1:0] rb_data;
  logic          wb_valid;
  logic [AW-1:0] wb_tgt;
  logic [DW-1:0] wb_data;
  logic          halted;
  logic [RW-1:0] retired;

  modport master (
    output bubble_in, opcode_in, tgt_in, result_in, mem_rdata, halt_in,
    output ra_addr, rb_addr,
    input  ra_data, rb_data, wb_valid, wb_tgt, wb_data, halted, retired
  );

  modport slave (
    input  bubble_in, opcode_in, tgt_in, result_in, mem_rdata, halt_in,
    input  ra_addr, rb_addr,
    output ra_data, rb_data, wb_valid, wb_tgt, wb_data, halted, retired
  );
endinterface

// File: rtl/writeback_regfile_regfile_2r1w.sv
// Register storage with one write port and two combinational read ports;
// r0 reads zero and reads of the register being written see the new value.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_ra_addr,
  input  logic [AW-1:0] i_rb_addr,
  output logic [DW-1:0] o_ra_data,
  output logic [DW-1:0] o_rb_data
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0] r_regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // The zero check comes first so r0 stays zero even when bypassed.
  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] addr,
                                              input logic          we,
                                              input logic [AW-1:0] waddr,
                                              input logic [DW-1:0] wdata,
                                              input logic [DW-1:0] stored);
    if (addr == '0)                 return '0;
    else if (we && (waddr == addr)) return wdata;
    else                            return stored;
  endfunction

  always_comb begin
    o_ra_data = read_port(i_ra_addr, i_we, i_waddr, i_wdata, r_regs[i_ra_addr]);
    o_rb_data = read_port(i_rb_addr, i_we, i_waddr, i_wdata, r_regs[i_rb_addr]);
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: selects load data or ALU result, commits it to the register
// file, and tracks the sticky halt flag and the saturating retire counter.
module writeback_regfile
  import cpu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW,
  parameter int RW = RET_W
) (
  input  logic clk,
  input  logic rst,
  writeback_regfile_if.slave bus
);

  logic          r_halted;
  logic [RW-1:0] r_retired;
  logic          w_live;
  logic          w_wb_valid;
  logic [DW-1:0] w_wb_data;

  // Load data is only routed through on LW so an undriven memory bus
  // cannot leak X into the writeback value.
  always_comb begin
    w_live     = !bus.bubble_in && !r_halted;
    w_wb_valid = w_live && !bus.halt_in && writes_reg(bus.opcode_in)
                 && (bus.tgt_in != '0);
    w_wb_data  = (bus.opcode_in == OP_LW) ? bus.mem_rdata : bus.result_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else if (w_live) begin
      if (bus.halt_in) r_halted <= 1'b1;
      if (r_retired != {RW{1'b1}}) r_retired <= r_retired + 1'b1;
    end
  end

  regfile_2r1w #(.DW(DW), .AW(AW)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_wb_valid),
    .i_waddr   (bus.tgt_in),
    .i_wdata   (w_wb_data),
    .i_ra_addr (bus.ra_addr),
    .i_rb_addr (bus.rb_addr),
    .o_ra_data (bus.ra_data),
    .o_rb_data (bus.rb_data)
  );

  assign bus.wb_valid = w_wb_valid;
  assign bus.wb_tgt   = bus.tgt_in;
  assign bus.wb_data  = w_wb_data;
  assign bus.halted   = r_halted;
  assign bus.retired  = r_retired;

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomised and directed stimulus for writeback_regfile, checked against an
// array-based architectural model through an expected-response queue.
module tb_writeback_regfile;

  localparam int EW = 1 + 3 + 16 + 16 + 16 + 1 + 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  writeback_regfile_if #(.DW(16), .AW(3), .RW(16)) bus ();

  writeback_regfile #(.DW(16), .AW(3), .RW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] m_regs [8];
  bit          m_halted;
  int unsigned m_retired;

  function automatic bit m_writes(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd3)
        || (op == 3'd5) || (op == 3'd7);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_halted  = 1'b0;
    m_retired = 0;
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q [$];
  string         tag_q [$];
  int            n_tests = 0;
  int            n_fail  = 0;

  always @(negedge clk) begin
    logic [EW-1:0] exp_v;
    logic [EW-1:0] act_v;
    string         tag;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      act_v = {bus.wb_valid, bus.wb_tgt, bus.wb_data, bus.ra_data, bus.rb_data,
               bus.halted, bus.retired};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s: got wbv=%0b tgt=%0d wbd=%h ra=%h rb=%h halted=%0b ret=%h | expected wbv=%0b tgt=%0d wbd=%h ra=%h rb=%h halted=%0b ret=%h",
                 tag, act_v[68], act_v[67:65], act_v[64:49], act_v[48:33], act_v[32:17],
                 act_v[16], act_v[15:0], exp_v[68], exp_v[67:65], exp_v[64:49],
                 exp_v[48:33], exp_v[32:17], exp_v[16], exp_v[15:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic bub, input logic [2:0] op, input logic [2:0] tgt,
                       input logic [15:0] res, input logic [15:0] mem, input logic hlt,
                       input logic [2:0] ra, input logic [2:0] rb, input string tag);
    bit          live, wbv;
    logic [15:0] wbd, rav, rbv;
    @(posedge clk);
    #1;
    bus.bubble_in = bub;
    bus.opcode_in = op;
    bus.tgt_in    = tgt;
    bus.result_in = res;
    bus.mem_rdata = mem;
    bus.halt_in   = hlt;
    bus.ra_addr   = ra;
    bus.rb_addr   = rb;
    live = !bub && !m_halted;
    wbv  = live && !hlt && m_writes(op) && (tgt != 3'd0);
    wbd  = (op == 3'd5) ? mem : res;
    rav  = (ra == 3'd0) ? 16'h0 : ((wbv && tgt == ra) ? wbd : m_regs[ra]);
    rbv  = (rb == 3'd0) ? 16'h0 : ((wbv && tgt == rb) ? wbd : m_regs[rb]);
    exp_q.push_back({wbv, tgt, wbd, rav, rbv, m_halted, m_retired[15:0]});
    tag_q.push_back(tag);
    if (!rst) begin
      if (wbv) m_regs[tgt] = wbd;
      if (live && hlt) m_halted = 1'b1;
      if (live && m_retired < 32'hFFFF) m_retired++;
    end
  endtask

  task automatic rand_drive(input bit allow_bubble, input string tag);
    logic [2:0] tgt;
    logic [2:0] ra, rb;
    logic       bub;
    tgt = 3'($urandom_range(0, 7));
    ra  = ($urandom_range(0, 2) == 0) ? tgt : 3'($urandom_range(0, 7));
    rb  = ($urandom_range(0, 2) == 0) ? tgt : 3'($urandom_range(0, 7));
    bub = allow_bubble && ($urandom_range(0, 7) == 0);
    drive(bub, 3'($urandom_range(0, 7)), tgt, 16'($urandom), 16'($urandom), 1'b0,
          ra, rb, tag);
  endtask

  // Asserts rst between edges and checks outputs before the next rising edge.
  task automatic reset_check(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    #1;
    drive_now(tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic drive_now(input string tag);
    bus.bubble_in = 1'b1;
    bus.opcode_in = 3'd0;
    bus.tgt_in    = 3'd3;
    bus.result_in = 16'h5555;
    bus.mem_rdata = 16'h0;
    bus.halt_in   = 1'b0;
    bus.ra_addr   = 3'd3;
    bus.rb_addr   = 3'd3;
    exp_q.push_back({1'b0, 3'd3, 16'h5555, 16'h0, 16'h0, 1'b0, 16'h0});
    tag_q.push_back(tag);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int guard;
    model_clear();
    bus.bubble_in = 1'b1;
    bus.opcode_in = 3'd0;
    bus.tgt_in    = 3'd0;
    bus.result_in = 16'h0;
    bus.mem_rdata = 16'h0;
    bus.halt_in   = 1'b0;
    bus.ra_addr   = 3'd0;
    bus.rb_addr   = 3'd0;
    reset_check("reset_state");

    drive(1'b0, 3'd0, 3'd3, 16'h1234, 16'h0,    1'b0, 3'd3, 3'd0, "add_bypass");
    drive(1'b0, 3'd5, 3'd5, 16'h0040, 16'hBEEF, 1'b0, 3'd3, 3'd5, "lw_after_add");
    drive(1'b0, 3'd4, 3'd5, 16'h9999, 16'h1111, 1'b0, 3'd5, 3'd3, "sw_no_write");
    drive(1'b0, 3'd1, 3'd0, 16'hFFFF, 16'h0,    1'b0, 3'd0, 3'd5, "addi_r0");
    drive(1'b1, 3'd0, 3'd2, 16'hAAAA, 16'h0,    1'b0, 3'd2, 3'd0, "bubble_add");
    drive(1'b0, 3'd6, 3'd2, 16'h7777, 16'h0,    1'b0, 3'd2, 3'd5, "beq_no_write");
    drive(1'b0, 3'd7, 3'd6, 16'h0102, 16'h0,    1'b0, 3'd6, 3'd6, "jalr_same_ports");
    drive(1'b0, 3'd3, 3'd2, 16'h8000, 16'hDEAD, 1'b0, 3'd2, 3'd6, "lui_ignores_mem");

    for (int i = 0; i < 300; i++) rand_drive(1'b1, "random");

    drive(1'b1, 3'd0, 3'd4, 16'h0007, 16'h0, 1'b1, 3'd4, 3'd3, "bubble_halt");
    drive(1'b0, 3'd0, 3'd4, 16'h0042, 16'h0, 1'b1, 3'd4, 3'd3, "halt_with_add");
    drive(1'b0, 3'd0, 3'd4, 16'h0007, 16'h0, 1'b0, 3'd4, 3'd3, "after_halt");
    for (int i = 0; i < 5; i++) rand_drive(1'b1, "halted_frozen");

    reset_check("reset_after_halt");
    drive(1'b0, 3'd0, 3'd3, 16'hCAFE, 16'h0, 1'b0, 3'd3, 3'd1, "rewrite_r3");
    while (m_retired < 32'hFFFE) rand_drive(1'b0, "preload");
    for (int i = 0; i < 3; i++) rand_drive(1'b0, "saturate");
    drive(1'b0, 3'd0, 3'd3, 16'h3333, 16'h0, 1'b0, 3'd3, 3'd0, "sat_hold_r3");
    drive(1'b1, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd3, 3'd0, "sat_peek");
    reset_check("reset_mid_cycle");
    drive(1'b1, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd3, 3'd7, "post_reset");

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Final stage of the pipelined CPU. Consumes the memory-stage outputs: opcode, target register, ALU/address result, bubble flag and halt flag.
- Selects the writeback value: load data from data memory for LW, otherwise the result. Commits it to an 8x16 register file.
- Serves the two decode-stage read ports with same-cycle write bypass, and provides a sticky halted flag and a retired-instruction counter.

Parameters:
- DATA_W, 16, register and datapath width
- REG_AW, 3, register address width (2**REG_AW registers; r0 hardwired zero)
- RET_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- bubble_in  in  1  memory-stage slot is empty
- opcode_in  in  3  opcode of instruction in slot
- tgt_in  in  REG_AW  destination register
- result_in  in  DATA_W  ALU result, or link value for JALR
- mem_rdata  in  DATA_W  data-memory read data for the slot's LW, valid this cycle
- halt_in  in  1  slot holds the halt instruction
- ra_addr  in  REG_AW  read port A address
- rb_addr  in  REG_AW  read port B address
- ra_data  out  DATA_W  read port A data (combinational)
- rb_data  out  DATA_W  read port B data (combinational)
- wb_valid  out  1  a register write commits at the next edge (for hazard/forward logic)
- wb_tgt  out  REG_AW  register being written
- wb_data  out  DATA_W  value being written
- halted  out  1  sticky: halt retired
- retired  out  RET_W  count of retired instructions

Behaviour:
- Opcodes: 000 ADD, 001 ADDI, 010 NAND, 011 LUI, 100 SW, 101 LW, 110 BEQ, 111 JALR.
- Writing opcodes are ADD, ADDI, NAND, LUI, LW, JALR. SW and BEQ never write.
- live = !bubble_in && !halted.
- wb_valid = live && !halt_in && writing opcode && tgt_in != 0. All combinational.
- wb_data = mem_rdata if opcode_in == LW, else result_in. wb_tgt = tgt_in.
- Rising edge with wb_valid: regs[tgt_in] <= wb_data. One write per cycle, zero extra latency.
- r0 is never written and always reads 0, including through bypass.
- Read ports:
  - ra_data = 0 if ra_addr == 0.
  - Else wb_data if wb_valid && wb_tgt == ra_addr (write-through bypass).
  - Else regs[ra_addr].
  - Port B is identical. Both ports may read the same register.
- Halt:
  - On an edge with live && halt_in, halted <= 1.
  - The halt instruction writes no register.
  - From the next cycle all writes and retire counting are suppressed until rst.
- retired:
  - Increments by 1 on every edge with live, whether or not the instruction writes; this includes the halt instruction.
  - Saturates at all-ones (no wrap).
  - Bubbles never count.
- Reset: rst high asynchronously clears all registers to 0, halted to 0 and retired to 0.
- Combinational outputs follow the cleared state immediately, so ra_data and rb_data read 0.
- Reset mid-stream discards the in-flight write.
- Simultaneous events:
  - halt_in together with a writing opcode: no write.
  - bubble_in together with halt_in: ignored, halted is not set.
- No X propagation: mem_rdata is muxed only when opcode_in == LW.

Decomposition:
- Shared package cpu_pkg holds: opcode localparams (OP_ADD … OP_JALR), DATA_W/REG_AW defaults, and the function writes_reg(opcode). Decode and hazard logic reuse these.
- One sub-module, regfile_2r1w: storage array, r0 masking, two bypassed read ports. The top contains the writeback mux, halt and counter logic.

Test Plan:
- Reset, then ADD tgt=3 result=0x1234 with bubble=0 -> wb_valid=1. Same cycle ra_addr=3 bypass gives 0x1234. After the edge regs[3]=0x1234 and retired=1.
- LW tgt=5 result=0x0040 mem_rdata=0xBEEF -> regs[5]=0xBEEF, not 0x0040. SW tgt=5 result=0x9999 -> regs[5] unchanged, retired still increments.
- ADDI tgt=0 result=0xFFFF -> wb_valid=0, ra_addr=0 reads 0. bubble_in=1 with ADD tgt=2 -> no write, retired unchanged.
- halt_in=1 non-bubble -> halted=1 next cycle, retired+1. Following ADD tgt=4 result=7 -> regs[4] unchanged, retired frozen.
- Preload retired to 0xFFFE via 0xFFFE live instructions, then 3 more -> retired=0xFFFF. Assert rst mid-cycle -> retired, halted and regs[3] read 0 before the next clk edge.
